// File: rtl/rf_writeback_arbiter_pkg.sv
// Shared constants for the register-file writeback arbiter.
// Defaults mirror the core-wide widths (XLEN, RF index width, RF register count)
// plus the long-latency writeback queue depth and the B-side starvation limit.
package rf_writeback_arbiter_pkg;

    localparam int unsigned WB_XLEN       = 32;
    localparam int unsigned WB_RFIDX_W    = 5;
    localparam int unsigned WB_RFREG_NUM  = 32;
    localparam int unsigned WB_PC_W       = 32;
    localparam int unsigned WB_BQ_DEPTH   = 4;
    localparam int unsigned WB_STARVE_MAX = 8;

    // Width of one queued B entry: {pc, rd, data}
    function automatic int unsigned wb_entry_w(input int unsigned xlen, input int unsigned rfidx_w);
        return WB_PC_W + rfidx_w + xlen;
    endfunction

endpackage

// File: rtl/rf_writeback_arbiter_wb_fifo.sv
// Synchronous FIFO holding long-latency writeback results.
// Ports:
//   clk, rstn   clock, async active-low reset (pointers and count only)
//   push, pop   enqueue din / dequeue head; both in one cycle is legal, even when full
//   din, dout   entry in / head entry out (dout valid when !empty_c)
//   full_c      count == DEPTH
//   empty_c     count == 0
//   count_c     occupancy, log2(DEPTH)+1 bits
module rf_writeback_arbiter_wb_fifo #(
    parameter int unsigned W     = 69,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       push,
    input  logic                       pop,
    input  logic [W-1:0]               din,
    output logic [W-1:0]               dout,
    output logic                       full_c,
    output logic                       empty_c,
    output logic [$clog2(DEPTH):0]     count_c
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [CW-1:0] cnt;
    logic          do_push;
    logic          do_pop;

    // A push on full only lands when the head leaves in the same cycle
    assign do_pop  = pop && !empty_c;
    assign do_push = push && (!full_c || do_pop);

    assign full_c  = (cnt == CW'(DEPTH));
    assign empty_c = (cnt == '0);
    assign count_c = cnt;
    assign dout    = mem[rptr];

    // Pointers and occupancy; DEPTH is a power of two so pointers wrap naturally
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (do_push) wptr <= wptr + AW'(1);
            if (do_pop)  rptr <= rptr + AW'(1);
            if (do_push && !do_pop)      cnt <= cnt + CW'(1);
            else if (!do_push && do_pop) cnt <= cnt - CW'(1);
        end
    end

    // Storage needs no reset; occupancy gates what is visible
    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= din;
    end

endmodule

// File: rtl/rf_writeback_arbiter.sv
// Register-file writeback arbiter: merges the in-order pipeline writeback (A) and
// queued long-latency results (B) onto the single RF write port, and keeps the
// pending-destination scoreboard read by decode hazard logic.
// Ports:
//   clk, rstn                         clock, async active-low reset
//   a_valid/a_ready/a_rd/a_data/a_pc  pipeline writeback; a_ready is combinational
//   b_valid/b_ready/b_rd/b_data/b_pc  long-latency push into the queue; b_ready = !full
//   iss_valid/iss_rd                  long-latency issue, marks iss_rd pending
//   pending                           registered scoreboard, bit 0 always 0
//   rf_we/rf_wa/rf_wd/rf_pc           registered RF write port, one cycle after grant
module rf_writeback_arbiter
    import rf_writeback_arbiter_pkg::*;
#(
    parameter int unsigned XLEN       = WB_XLEN,
    parameter int unsigned RFIDX_W    = WB_RFIDX_W,
    parameter int unsigned RFREG_NUM  = WB_RFREG_NUM,
    parameter int unsigned BQ_DEPTH   = WB_BQ_DEPTH,
    parameter int unsigned STARVE_MAX = WB_STARVE_MAX
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  a_valid,
    output logic                  a_ready,
    input  logic [RFIDX_W-1:0]    a_rd,
    input  logic [XLEN-1:0]       a_data,
    input  logic [WB_PC_W-1:0]    a_pc,
    input  logic                  b_valid,
    output logic                  b_ready,
    input  logic [RFIDX_W-1:0]    b_rd,
    input  logic [XLEN-1:0]       b_data,
    input  logic [WB_PC_W-1:0]    b_pc,
    input  logic                  iss_valid,
    input  logic [RFIDX_W-1:0]    iss_rd,
    output logic [RFREG_NUM-1:0]  pending,
    output logic                  rf_we,
    output logic [RFIDX_W-1:0]    rf_wa,
    output logic [XLEN-1:0]       rf_wd,
    output logic [WB_PC_W-1:0]    rf_pc
);

    localparam int unsigned EW = wb_entry_w(XLEN, RFIDX_W);
    localparam int unsigned SW = $clog2(STARVE_MAX + 1);
    localparam int unsigned CW = $clog2(BQ_DEPTH) + 1;

    logic [EW-1:0]         bq_dout;
    logic                  bq_full;
    logic                  bq_empty;
    logic [CW-1:0]         bq_count;
    logic                  bq_push;

    logic [WB_PC_W-1:0]    head_pc;
    logic [RFIDX_W-1:0]    head_rd;
    logic [XLEN-1:0]       head_data;

    logic [SW-1:0]         starve_cnt;
    logic                  grant_a;
    logic                  grant_b;
    logic [RFREG_NUM-1:0]  pending_nxt;

    // Long-latency result queue
    assign bq_push = b_valid && b_ready;

    rf_writeback_arbiter_wb_fifo #(
        .W     (EW),
        .DEPTH (BQ_DEPTH)
    ) u_wb_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .push    (bq_push),
        .pop     (grant_b),
        .din     ({b_pc, b_rd, b_data}),
        .dout    (bq_dout),
        .full_c  (bq_full),
        .empty_c (bq_empty),
        .count_c (bq_count)
    );

    assign head_pc   = bq_dout[EW-1 -: WB_PC_W];
    assign head_rd   = bq_dout[XLEN +: RFIDX_W];
    assign head_data = bq_dout[XLEN-1:0];

    // A has priority unless B's head has waited STARVE_MAX A wins
    assign grant_b = !bq_empty && (!a_valid || (starve_cnt == SW'(STARVE_MAX)));
    assign grant_a = a_valid && !grant_b;
    assign a_ready = !grant_b;
    // No pop look-through: a full queue refuses pushes even while draining
    assign b_ready = !bq_full;

    // Starvation counter: counts A wins over a waiting B head
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            starve_cnt <= '0;
        end else if (bq_empty || grant_b) begin
            starve_cnt <= '0;
        end else if (grant_a && (starve_cnt != SW'(STARVE_MAX))) begin
            starve_cnt <= starve_cnt + SW'(1);
        end
    end

    // Scoreboard update; the set is applied last so a same-index set beats the retire clear
    always_comb begin
        pending_nxt = pending;
        if (grant_b) pending_nxt[head_rd] = 1'b0;
        if (iss_valid && (iss_rd != '0)) pending_nxt[iss_rd] = 1'b1;
        pending_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) pending <= '0;
        else       pending <= pending_nxt;
    end

    // RF write port; writes to x0 are consumed but never enabled
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rf_we <= 1'b0;
            rf_wa <= '0;
            rf_wd <= '0;
            rf_pc <= '0;
        end else if (grant_b) begin
            rf_we <= (head_rd != '0);
            rf_wa <= head_rd;
            rf_wd <= head_data;
            rf_pc <= head_pc;
        end else if (grant_a) begin
            rf_we <= (a_rd != '0);
            rf_wa <= a_rd;
            rf_wd <= a_data;
            rf_pc <= a_pc;
        end else begin
            rf_we <= 1'b0;
        end
    end

`ifndef SYNTHESIS
    // Issue logic must never let A write a register still owned by an in-flight B result
    a_b_rd_overlap: assert property (@(posedge clk) disable iff (!rstn)
        !(grant_a && (a_rd != '0) && pending[a_rd]))
        else $error("A writeback to rd %0d while a long-latency result is pending", a_rd);

    bq_count_bound: assert property (@(posedge clk) disable iff (!rstn)
        bq_count <= CW'(BQ_DEPTH))
        else $error("writeback queue occupancy out of range: %0d", bq_count);
`endif

endmodule
